// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared single-cycle 32-bit ALU.
// Operands are latched at grant, the ALU runs for one EXEC cycle, and the result is held until its owner takes it.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid0,
  input  logic              req_valid1,
  output logic              req_ready0,
  output logic              req_ready1,
  input  logic [DATA_W-1:0] req_in1_0,
  input  logic [DATA_W-1:0] req_in2_0,
  input  logic [DATA_W-1:0] req_in1_1,
  input  logic [DATA_W-1:0] req_in2_1,
  input  logic [3:0]        req_op_0,
  input  logic [3:0]        req_op_1,
  input  logic [4:0]        req_shmt_0,
  input  logic [4:0]        req_shmt_1,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  input  logic              rsp_ready0,
  input  logic              rsp_ready1,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_op,
  output logic [4:0]        alu_shmt,
  input  logic [DATA_W-1:0] alu_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q;
  logic              last_q;
  logic              owner_q;
  logic [DATA_W-1:0] in1_q, in2_q, rsp_out_q;
  logic [3:0]        op_q;
  logic [4:0]        shmt_q;
  logic              rsp_zero_q, rsp_err_q, rsp_valid0_q, rsp_valid1_q;

  logic              grant1_d;
  logic              legal_d;
  logic [DATA_W-1:0] res_d;
  logic              rsp_take_d;

  // Port 1 wins when it is the only one asking, or on a tie when port 0 went last.
  assign grant1_d   = req_valid1 && (!req_valid0 || !last_q);
  assign req_ready1 = (state_q == IDLE) && grant1_d;
  assign req_ready0 = (state_q == IDLE) && req_valid0 && !grant1_d;

  always_comb begin
    legal_d = 1'b0;
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b0110, 4'b0111, 4'b1100: legal_d = 1'b1;
      default:                   legal_d = 1'b0;
    endcase
  end

  assign res_d      = legal_d ? alu_out : '0;
  assign rsp_take_d = owner_q ? rsp_ready1 : rsp_ready0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      in1_q        <= '0;
      in2_q        <= '0;
      op_q         <= '0;
      shmt_q       <= '0;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_ready0) begin
            in1_q   <= req_in1_0;
            in2_q   <= req_in2_0;
            op_q    <= req_op_0;
            shmt_q  <= req_shmt_0;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= EXEC;
          end else if (req_ready1) begin
            in1_q   <= req_in1_1;
            in2_q   <= req_in2_1;
            op_q    <= req_op_1;
            shmt_q  <= req_shmt_1;
            owner_q <= 1'b1;
            last_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_out_q    <= res_d;
          rsp_zero_q   <= (res_d == '0);
          rsp_err_q    <= !legal_d;
          rsp_valid0_q <= !owner_q;
          rsp_valid1_q <= owner_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_take_d) begin
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_op     = op_q;
  assign alu_shmt   = shmt_q;
  assign rsp_out    = rsp_out_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU answers the DUT and every check is an immediate assertion.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid0, req_valid1, req_ready0, req_ready1;
  logic [31:0] req_in1_0, req_in2_0, req_in1_1, req_in2_1;
  logic [3:0]  req_op_0, req_op_1;
  logic [4:0]  req_shmt_0, req_shmt_1;
  logic        rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1;
  logic [31:0] rsp_out;
  logic        rsp_zero, rsp_err;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shmt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_in1_0(req_in1_0), .req_in2_0(req_in2_0),
    .req_in1_1(req_in1_1), .req_in2_1(req_in2_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .req_shmt_0(req_shmt_0), .req_shmt_1(req_shmt_1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_shmt(alu_shmt), .alu_out(alu_out)
  );

  // Illegal codes return garbage so that masking to zero is visible.
  always_comb begin
    alu_out = 32'hDEAD_BEEF;
    case (alu_op)
      4'b0000: alu_out = alu_in1 & alu_in2;
      4'b0001: alu_out = alu_in1 | alu_in2;
      4'b0010: alu_out = alu_in1 + alu_in2;
      4'b0100: alu_out = alu_in2 << alu_shmt;
      4'b0110: alu_out = alu_in1 - alu_in2;
      4'b0111: alu_out = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
      4'b1100: alu_out = ~(alu_in1 | alu_in2);
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single operation on one port with rsp_ready asserted on the first RESP cycle.
  task automatic do_op(input int port, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       input logic [31:0] eo, input logic ez, input logic ee);
    if (port == 0) begin
      req_valid0 = 1'b1; req_op_0 = op; req_in1_0 = a; req_in2_0 = b; req_shmt_0 = sh;
    end else begin
      req_valid1 = 1'b1; req_op_1 = op; req_in1_1 = a; req_in2_1 = b; req_shmt_1 = sh;
    end
    @(negedge clk);
    chk("op_req_ready", (port == 0) ? req_ready0 : req_ready1, 1'b1);
    @(posedge clk); #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    @(negedge clk);
    chk("op_exec_alu_op", alu_op, op);
    chk("op_exec_no_rsp", rsp_valid0 | rsp_valid1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("op_rsp_valid_own", (port == 0) ? rsp_valid0 : rsp_valid1, 1'b1);
    chk("op_rsp_valid_other", (port == 0) ? rsp_valid1 : rsp_valid0, 1'b0);
    chk("op_rsp_out", rsp_out, eo);
    chk("op_rsp_zero", rsp_zero, ez);
    chk("op_rsp_err", rsp_err, ee);
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
    @(negedge clk);
    chk("op_rsp_done", rsp_valid0 | rsp_valid1, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    req_valid0 = 1'b0; req_valid1 = 1'b0; rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
    req_in1_0 = '0; req_in2_0 = '0; req_in1_1 = '0; req_in2_1 = '0;
    req_op_0 = '0; req_op_1 = '0; req_shmt_0 = '0; req_shmt_1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
    chk("rst_rsp_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
    chk("rst_rsp_out", rsp_out, 32'd0);
    chk("rst_alu_in", alu_in1 | alu_in2, 32'd0);
    chk("rst_alu_op_shmt", {23'd0, alu_op, alu_shmt}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ADD 5+7 on port 0
    do_op(0, 4'b0010, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0);

    // SUB 9-9 on port 1 with four cycles of backpressure; port 0's rsp_ready must be ignored
    req_valid1 = 1'b1; req_op_1 = 4'b0110; req_in1_1 = 32'd9; req_in2_1 = 32'd9;
    rsp_ready0 = 1'b1;
    @(negedge clk);
    chk("bp_req_ready1", req_ready1, 1'b1);
    chk("bp_req_ready0", req_ready0, 1'b0);
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    @(negedge clk);
    chk("bp_exec_no_rsp", rsp_valid1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_valid1", rsp_valid1, 1'b1);
      chk("bp_hold_valid0", rsp_valid0, 1'b0);
      chk("bp_hold_out", rsp_out, 32'd0);
      chk("bp_hold_zero", rsp_zero, 1'b1);
    end
    rsp_ready1 = 1'b1;
    @(posedge clk); #1;
    rsp_ready1 = 1'b0; rsp_ready0 = 1'b0;
    req_valid1 = 1'b1;
    @(negedge clk);
    chk("bp_done_valid1", rsp_valid1, 1'b0);
    chk("bp_idle_ready1", req_ready1, 1'b1);
    req_valid1 = 1'b0;
    @(posedge clk); #1;

    // Both ports continuously valid: grants alternate 0,1,0,1 at 3 cycles per op
    req_valid0 = 1'b1; req_op_0 = 4'b0010; req_in1_0 = 32'd1;  req_in2_0 = 32'd1;
    req_valid1 = 1'b1; req_op_1 = 4'b0010; req_in1_1 = 32'd10; req_in2_1 = 32'd20;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_ready0", req_ready0, (k % 2 == 0));
      chk("rr_ready1", req_ready1, (k % 2 == 1));
      @(posedge clk);
      @(negedge clk);
      chk("rr_exec_ready", {req_ready1, req_ready0}, 32'd0);
      chk("rr_exec_rsp", {rsp_valid1, rsp_valid0}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rr_rsp_valid0", rsp_valid0, (k % 2 == 0));
      chk("rr_rsp_valid1", rsp_valid1, (k % 2 == 1));
      chk("rr_rsp_out", rsp_out, (k % 2 == 0) ? 32'd2 : 32'd30);
      @(posedge clk);
    end
    #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0; rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
    @(posedge clk); #1;

    // Illegal op, SLL, SLT, NOR
    do_op(0, 4'b1111, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1, 1'b1);
    do_op(0, 4'b0100, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    do_op(1, 4'b0111, 32'd3, 32'd4, 5'd0, 32'd1, 1'b0, 1'b0);
    do_op(0, 4'b1100, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset during EXEC drops the operation and restores port-0 priority
    req_valid0 = 1'b1; req_op_0 = 4'b0010; req_in1_0 = 32'd1; req_in2_0 = 32'd2;
    @(negedge clk);
    chk("rx_ready0", req_ready0, 1'b1);
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    chk("rx_exec_in1", alu_in1, 32'd1);
    reset = 1'b1;
    #1;
    chk("rx_async_alu_in1", alu_in1, 32'd0);
    chk("rx_async_alu_op", alu_op, 32'd0);
    chk("rx_async_rsp", {rsp_valid1, rsp_valid0}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rx_no_rsp", {rsp_valid1, rsp_valid0}, 32'd0);
    end
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    #1;
    chk("rx_prio_ready0", req_ready0, 1'b1);
    chk("rx_prio_ready1", req_ready1, 1'b0);
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle 32-bit ALU between two requesters, e.g. the main execute stage and an auxiliary address/branch unit. Each requester has an independent valid/ready request channel and valid/ready response channel. Grants alternate round-robin, operands are registered, and the ALU is driven for one EXEC cycle. The result and zero flag are then held in a response register until the owning requester accepts them.

## Interface
- DATA_W, 32: operand/result width; must match the ALU.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid0 / req_valid1  in  1  requester n presents an operation.
- req_ready0 / req_ready1  out  1  arbiter accepts requester n this cycle.
- req_in1_n, req_in2_n (n=0,1)  in  DATA_W  operands.
- req_op_n  in  4  ALU op code: AND 0000, OR 0001, ADD 0010, SLL 0100, SUB 0110, SLT 0111, NOR 1100.
- req_shmt_n  in  5  shift amount; used only by SLL.
- rsp_valid0 / rsp_valid1  out  1  result for requester n available.
- rsp_ready0 / rsp_ready1  in  1  requester n takes the result.
- rsp_out  out  DATA_W  registered result; shared bus, qualified by rsp_valid_n.
- rsp_zero  out  1  rsp_out == 0, computed locally and registered.
- rsp_err  out  1  op code was not in the legal set.
- alu_in1, alu_in2  out  DATA_W  to the ALU.
- alu_op  out  4  to the ALU.
- alu_shmt  out  5  to the ALU.
- alu_out  in  DATA_W  from the ALU, combinational.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Priority pointer `last` (1 bit) resets to 1, so port 0 wins first.

IDLE
- Grant goes to the valid port.
- If both ports are valid, grant goes to the port != last.
- req_ready_n = (state==IDLE) && grant==n. It is combinational from req_valid and last.
- On handshake: latch in1, in2, op, shmt, owner=n; set last=n; go to EXEC.

EXEC
- alu_* outputs are driven from the latched registers.
- At the clock edge:
  - Capture rsp_out = legal ? alu_out : 0.
  - Capture rsp_zero = (captured value == 0).
  - Capture rsp_err = !legal.
  - Go to RESP.
- Legality is decoded from the latched op against the seven codes. The ALU output for an illegal op is never used.

RESP
- rsp_valid_owner = 1 and the other port's rsp_valid = 0.
- Hold all rsp fields until rsp_ready_owner = 1.
- On response handshake, go to IDLE.
- The rsp_ready of the non-owner is ignored.

Other rules:
- alu_* outputs outside EXEC hold the latched values. They are 0 after reset.
- Requests are not accepted in EXEC or RESP; req_ready0 = req_ready1 = 0.
- A requester may drop req_valid before it is accepted without consequence.
- Arithmetic and flags are exactly the ALU's. SLT is unsigned, matching the ALU; its result is 1 or 0.

## Timing
- Reset values, asynchronous:
  - state=IDLE, last=1.
  - All latched registers 0; owner=0.
  - rsp_out=0, rsp_zero=0, rsp_err=0, rsp_valid0/1=0.
  - alu_in1=alu_in2=0, alu_op=0000, alu_shmt=0.
- Latency: accept at edge T, EXEC during T→T+1, rsp_valid high from T+1.
- Minimum occupancy is 3 cycles per operation (IDLE, EXEC, RESP) with rsp_ready held high.
- Back-to-back requests:
  - After the RESP handshake at edge R, the next accept can occur at edge R+1.
  - With both ports continuously valid, grants alternate 0,1,0,1.
- Response simultaneous with a new request: the new request waits in IDLE one cycle; there is no bypass.
- Backpressure: rsp_ready low for k cycles extends RESP by k cycles. rsp fields stay stable throughout.
- Reset mid-operation (EXEC or RESP):
  - The in-flight operation is dropped and no response is issued.
  - All outputs go to reset values immediately.

## Test plan
- Reset, then port 0 ADD 5+7 → req_ready0=1 at accept; rsp_valid0 2 cycles later; rsp_out=12, rsp_zero=0, rsp_err=0.
- Port 1 SUB 9-9 with rsp_ready1 held low 4 cycles → rsp_valid1 held 4 cycles; rsp_out=0, rsp_zero=1 stable; IDLE after handshake.
- Both ports valid for 4 operations with rsp_ready high → grant order 0,1,0,1; each response goes only to its owner; 3 cycles per operation.
- Port 0 op 1111 → rsp_out=0, rsp_zero=1, rsp_err=1. Then SLL in2=1, shmt=31 → rsp_out=0x80000000, rsp_err=0.
- SLT 3<4 → rsp_out=1. NOR 0,0 → rsp_out equals the ALU's output for those operands.
- reset asserted during EXEC → no rsp_valid. After release, port 0 wins first when both ports are valid.
